// File: rtl/imem_fetch_responder.sv
// Wait-stated instruction ROM responder: one fetch in flight, response LATENCY cycles after accept.
// Optional IMEM_BOUNDS_CHECK_EN flags misaligned/out-of-range fetches with a NOP and rsp_fault.
module imem_fetch_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LATENCY   = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_fault
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fault_q, fault_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [31:0]       offset;
  logic [IDX_W-1:0]  req_idx;
  logic              req_fault;
  logic              accept;
  logic              load_rsp;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_fault;

  // NOTE: the ROM is never reset.
  logic [31:0] rom_mem [DEPTH];

  assign offset  = req_addr - BASE_ADDR;
  assign req_idx = offset[IDX_W+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic unused_offset_bits;
  assign unused_offset_bits = ^offset[1:0];
  assign req_fault = (req_addr[1:0] != 2'b00) || (offset[31:IDX_W+2] != '0);
  assign rsp_fault = rsp_fault_q;
`else
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0], rsp_fault_q};
  assign req_fault = 1'b0;
  assign rsp_fault = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    fault_d     = fault_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    req_ready   = 1'b0;
    load_rsp    = 1'b0;

    // Flush only gates acceptance while a fetch is in flight; IDLE ignores it.
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = rsp_ready && !flush;
      default: req_ready = 1'b0;
    endcase
    accept = req_valid && req_ready;

    if (flush && state_q != IDLE) begin
      state_d = IDLE;
    end else if (accept) begin
      idx_d   = req_idx;
      fault_d = req_fault;
      cnt_d   = CNT_INIT;
      if (LATENCY == 1) begin
        state_d  = RESP;
        load_rsp = 1'b1;
      end else begin
        state_d = WAIT;
      end
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = RESP;
            load_rsp = 1'b1;
          end
        end
        RESP:    if (rsp_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end

    // At LATENCY=1 the word is read straight from the request being accepted.
    rd_idx   = accept ? req_idx : idx_q;
    rd_fault = accept ? req_fault : fault_q;
    if (load_rsp) begin
      rsp_data_d  = rd_fault ? NOP : rom_mem[rd_idx];
      rsp_fault_d = rd_fault;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      fault_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fault_q     <= fault_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench: three responders (LATENCY 1, 3, 4) sharing one clock; ROMs are back-door loaded.
module tb_imem_fetch_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_ready;
  logic [2:0][31:0] req_addr;
  logic [2:0]       flush;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_ready;
  logic [2:0][31:0] rsp_data;
  logic [2:0]       rsp_fault;

  int n_checks = 0;
  int n_errors = 0;

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_fetch_responder #(
      .DEPTH    (1024),
      .BASE_ADDR(32'h0),
      .LATENCY  (g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .INIT_FILE("")
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .flush    (flush[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_data (rsp_data[g]),
      .rsp_fault(rsp_fault[g])
    );
  end

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        fl;
    logic        rr;
    logic        e_rdy;
    logic        e_vld;
    logic        chk_d;
    logic [31:0] e_data;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] word(int i);
    return (i == 0) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(i));
  endfunction

  function automatic vec_t mk(logic rv, logic [31:0] addr, logic fl, logic rr, logic e_rdy,
                              logic e_vld, logic chk_d, logic [31:0] e_data, logic e_flt);
    vec_t v;
    v.rv = rv; v.addr = addr; v.fl = fl; v.rr = rr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.chk_d = chk_d; v.e_data = e_data; v.e_flt = e_flt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(int k, logic rv, logic [31:0] a, logic fl, logic rr);
    req_valid[k] = rv;
    req_addr[k]  = a;
    flush[k]     = fl;
    rsp_ready[k] = rr;
  endtask

  task automatic expect_out(int k, string tag, logic e_rdy, logic e_vld);
    check({tag, ".req_ready"}, 32'(req_ready[k]), 32'(e_rdy));
    check({tag, ".rsp_valid"}, 32'(rsp_valid[k]), 32'(e_vld));
  endtask

  initial begin
    logic [31:0] w_bad;
    w_bad = BC ? 32'h0000_0013 : word(0);

    rst = 3'b111;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      g_dut[0].u_dut.rom_mem[i] = word(i);
      g_dut[1].u_dut.rom_mem[i] = word(i);
      g_dut[2].u_dut.rom_mem[i] = word(i);
    end

    // Two reset edges, then release and check the reset state of every instance.
    repeat (2) @(negedge clk);
    rst = 3'b000;
    #1;
    for (int k = 0; k < 3; k++) begin
      expect_out(k, $sformatf("reset%0d", k), 1'b1, 1'b0);
      check($sformatf("reset%0d.rsp_data", k), rsp_data[k], 32'h0);
      check($sformatf("reset%0d.rsp_fault", k), 32'(rsp_fault[k]), 32'h0);
    end

    //          rv    addr        fl    rr    rdy   vld   chk   data      flt
    vecs.push_back(mk(1, 32'h0,    0, 1, 1, 0, 0, 32'h0,   0));  // first fetch, addr 0
    vecs.push_back(mk(0, 32'h0,    0, 1, 1, 1, 1, word(0), 0));
    vecs.push_back(mk(1, 32'h0,    0, 1, 1, 0, 0, 32'h0,   0));  // streaming 0,4,8,12
    vecs.push_back(mk(1, 32'h4,    0, 1, 1, 1, 1, word(0), 0));
    vecs.push_back(mk(1, 32'h8,    0, 1, 1, 1, 1, word(1), 0));
    vecs.push_back(mk(1, 32'hC,    0, 1, 1, 1, 1, word(2), 0));
    vecs.push_back(mk(0, 32'h0,    0, 1, 1, 1, 1, word(3), 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0, 32'h0,   0));
    vecs.push_back(mk(1, 32'h14,   0, 0, 1, 0, 0, 32'h0,   0));  // backpressure
    vecs.push_back(mk(1, 32'h18,   0, 0, 0, 1, 1, word(5), 0));
    vecs.push_back(mk(1, 32'h18,   0, 0, 0, 1, 1, word(5), 0));
    vecs.push_back(mk(1, 32'h18,   0, 1, 1, 1, 1, word(5), 0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 0, 1, 1, word(6), 0));  // flush in RESP
    vecs.push_back(mk(1, 32'h1C,   1, 1, 1, 0, 0, 32'h0,   0));  // flush ignored in IDLE
    vecs.push_back(mk(0, 32'h0,    0, 1, 1, 1, 1, word(7), 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0, 32'h0,   0));
    vecs.push_back(mk(1, 32'h1000, 0, 1, 1, 0, 0, 32'h0,   0));  // wrap / out of range
    vecs.push_back(mk(1, 32'h2,    0, 1, 1, 1, 1, w_bad,   BC)); // misaligned
    vecs.push_back(mk(1, 32'h4,    0, 1, 1, 1, 1, w_bad,   BC));
    vecs.push_back(mk(0, 32'h0,    0, 1, 1, 1, 1, word(1), 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0, 32'h0,   0));

    foreach (vecs[i]) begin
      drive(0, vecs[i].rv, vecs[i].addr, vecs[i].fl, vecs[i].rr);
      #1;
      expect_out(0, $sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld);
      if (vecs[i].chk_d) begin
        check($sformatf("vec%0d.rsp_data", i), rsp_data[0], vecs[i].e_data);
        check($sformatf("vec%0d.rsp_fault", i), 32'(rsp_fault[0]), 32'(vecs[i].e_flt));
      end
      @(negedge clk);
    end

    // Reset while holding a response with rsp_ready low and a new request pending.
    drive(0, 1'b1, 32'h8, 1'b0, 1'b0);
    #1 expect_out(0, "rstmid.accept", 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 32'hC, 1'b0, 1'b0);
    rst[0] = 1'b1;
    #1 check("rstmid.held_data", rsp_data[0], word(2));
    @(negedge clk);
    rst[0] = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    expect_out(0, "rstmid.after", 1'b1, 1'b0);
    check("rstmid.rsp_data", rsp_data[0], 32'h0);

    // LATENCY=4: response exactly four cycles after accept, then stalled for three cycles.
    drive(2, 1'b1, 32'h8, 1'b0, 1'b0);
    #1 expect_out(2, "lat4.accept", 1'b1, 1'b0);
    @(negedge clk);
    for (int j = 1; j <= 3; j++) begin
      drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
      #1 expect_out(2, $sformatf("lat4.wait%0d", j), 1'b0, 1'b0);
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++) begin
      drive(2, 1'b1, 32'h10, 1'b0, 1'b0);
      #1 expect_out(2, $sformatf("lat4.stall%0d", j), 1'b0, 1'b1);
      check($sformatf("lat4.stall%0d.data", j), rsp_data[2], word(2));
      @(negedge clk);
    end
    drive(2, 1'b0, 32'h0, 1'b0, 1'b1);
    #1 expect_out(2, "lat4.take", 1'b1, 1'b1);
    check("lat4.take.data", rsp_data[2], word(2));
    @(negedge clk);
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 expect_out(2, "lat4.idle", 1'b1, 1'b0);

    // LATENCY=3: flush in the second WAIT cycle beats a simultaneous request.
    drive(1, 1'b1, 32'h4, 1'b0, 1'b0);
    #1 expect_out(1, "flush.accept", 1'b1, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 expect_out(1, "flush.wait1", 1'b0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 32'hC, 1'b1, 1'b0);
    #1 expect_out(1, "flush.wait2", 1'b0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 32'hC, 1'b0, 1'b0);
    #1 expect_out(1, "flush.reaccept", 1'b1, 1'b0);
    @(negedge clk);
    for (int j = 1; j <= 2; j++) begin
      drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
      #1 expect_out(1, $sformatf("flush.wait_new%0d", j), 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(1, 1'b0, 32'h0, 1'b0, 1'b1);
    #1 expect_out(1, "flush.resp", 1'b1, 1'b1);
    check("flush.resp.data", rsp_data[1], word(3));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
